// File: rtl/canvas_pkg.sv
// Canvas geometry, colour width and paint-controller state encoding shared by
// the paint controller and the display-side address generation.
package canvas_pkg;
    localparam int H_PIXELS = 320;
    localparam int V_PIXELS = 240;
    localparam int COLOR_W  = 4;
    localparam int ADDR_W   = $clog2(H_PIXELS * V_PIXELS);

    localparam logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(0);
    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(H_PIXELS * V_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } paint_state_t;
endpackage

// File: rtl/canvas_addr_gen.sv
// Maps an unclipped pixel coordinate to a linear canvas address and reports
// whether that coordinate lies on the canvas.
module canvas_addr_gen
    import canvas_pkg::*;
(
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    output logic              in_bounds_out,
    output logic [ADDR_W-1:0] addr_out
);

    assign in_bounds_out = (x_in < 11'(H_PIXELS)) && (y_in < 10'(V_PIXELS));
    assign addr_out      = ADDR_W'(y_in) * ADDR_W'(H_PIXELS) + ADDR_W'(x_in);

endmodule

// File: rtl/canvas_paint_ctrl.sv
// Owns the canvas write port: stamps a square brush per frame while the pen is
// down and sweeps the whole canvas with CLEAR_COLOR on request.
//
//   state | meaning
//   IDLE  | no job; waits for a pending clear or a pen-down frame
//   PAINT | walks the brush square, dx fastest, skipping clipped pixels
//   CLEAR | writes CLEAR_COLOR to every address, 0 to LAST_ADDR
module canvas_paint_ctrl
    import canvas_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               nf_in,
    input  logic               pen_down_in,
    input  logic               clear_in,
    input  logic [9:0]         cursor_loc_x,
    input  logic [8:0]         cursor_loc_y,
    input  logic [COLOR_W-1:0] cursor_color,
    input  logic [2:0]         stroke_width,
    output logic               wr_en_out,
    input  logic               wr_ready_in,
    output logic [ADDR_W-1:0]  wr_addr_out,
    output logic [COLOR_W-1:0] wr_data_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               frame_drop_out
);

    paint_state_t       state_q, state_d;
    logic               clear_pend_q, clear_pend_d;
    logic [9:0]         x0_q, x0_d;
    logic [8:0]         y0_q, y0_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [2:0]         side_m1_q, side_m1_d;
    logic [2:0]         dx_q, dx_d;
    logic [2:0]         dy_q, dy_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;

    logic               clear_req;
    logic               advance;
    logic               enter_clear;
    logic [ADDR_W-1:0]  clr_addr_d;
    logic [10:0]        pix_x;
    logic [9:0]         pix_y;
    logic               pix_in_bounds;
    logic [ADDR_W-1:0]  pix_addr;

    // A clear_in arriving this cycle already wins over a same-cycle frame.
    assign clear_req = clear_pend_q || clear_in;
    assign advance   = !wr_en_q || wr_ready_in;

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        color_d     = color_q;
        side_m1_d   = side_m1_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        clr_addr_d  = wr_addr_q;
        enter_clear = 1'b0;
        done_d      = 1'b0;
        drop_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    enter_clear = 1'b1;
                    drop_d      = nf_in;
                end else if (nf_in && pen_down_in) begin
                    state_d   = PAINT;
                    x0_d      = cursor_loc_x;
                    y0_d      = cursor_loc_y;
                    color_d   = cursor_color;
                    side_m1_d = stroke_width;
                    dx_d      = 3'd0;
                    dy_d      = 3'd0;
                end
            end
            PAINT: begin
                drop_d = nf_in;
                if (advance) begin
                    if (dx_q == side_m1_q && dy_q == side_m1_q) begin
                        done_d = 1'b1;
                        if (clear_req) enter_clear = 1'b1;
                        else           state_d     = IDLE;
                    end else if (dx_q == side_m1_q) begin
                        dx_d = 3'd0;
                        dy_d = dy_q + 3'd1;
                    end else begin
                        dx_d = dx_q + 3'd1;
                    end
                end
            end
            CLEAR: begin
                drop_d = nf_in;
                if (wr_ready_in) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        clr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_clear) state_d = CLEAR;
        clear_pend_d = enter_clear ? 1'b0 : (clear_pend_q || clear_in);
    end

    // Outputs are registered, so they are derived from the pixel about to be current.
    assign pix_x = {1'b0, x0_d} + {8'd0, dx_d};
    assign pix_y = {1'b0, y0_d} + {7'd0, dy_d};

    canvas_addr_gen u_addr_gen (
        .x_in          (pix_x),
        .y_in          (pix_y),
        .in_bounds_out (pix_in_bounds),
        .addr_out      (pix_addr)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_d)
            PAINT: begin
                wr_en_d   = pix_in_bounds;
                wr_addr_d = pix_addr;
                wr_data_d = color_d;
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = enter_clear ? '0 : clr_addr_d;
                wr_data_d = CLEAR_COLOR;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            color_q      <= '0;
            side_m1_q    <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            color_q      <= color_d;
            side_m1_q    <= side_m1_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    assign wr_en_out      = wr_en_q;
    assign wr_addr_out    = wr_addr_q;
    assign wr_data_out    = wr_data_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign frame_drop_out = drop_q;

endmodule

// File: tb/tb_canvas_paint_ctrl.sv
// Self-checking bench for canvas_paint_ctrl: directed and randomised brush
// jobs, backpressure, clipping, clear arbitration and mid-job reset.
module tb_canvas_paint_ctrl;
    import canvas_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_n_in = 1'b0;
    logic               nf_in = 1'b0;
    logic               pen_down_in = 1'b0;
    logic               clear_in = 1'b0;
    logic [9:0]         cursor_loc_x = '0;
    logic [8:0]         cursor_loc_y = '0;
    logic [COLOR_W-1:0] cursor_color = '0;
    logic [2:0]         stroke_width = '0;
    logic               wr_ready_in = 1'b0;
    logic               wr_en_out;
    logic [ADDR_W-1:0]  wr_addr_out;
    logic [COLOR_W-1:0] wr_data_out;
    logic               busy_out;
    logic               done_out;
    logic               frame_drop_out;

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int exp_data[$];
    int got_addr[$];
    int got_data[$];

    canvas_paint_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .nf_in          (nf_in),
        .pen_down_in    (pen_down_in),
        .clear_in       (clear_in),
        .cursor_loc_x   (cursor_loc_x),
        .cursor_loc_y   (cursor_loc_y),
        .cursor_color   (cursor_color),
        .stroke_width   (stroke_width),
        .wr_en_out      (wr_en_out),
        .wr_ready_in    (wr_ready_in),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .frame_drop_out (frame_drop_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time exceeded, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reference: every canvas pixel covered by the square, row by row, left to right.
    function automatic void model_brush(input int x, input int y, input int sw, input int col);
        exp_addr.delete();
        exp_data.delete();
        for (int dy = 0; dy <= sw; dy++)
            for (int dx = 0; dx <= sw; dx++)
                if (x + dx < H_PIXELS && y + dy < V_PIXELS) begin
                    exp_addr.push_back((y + dy) * H_PIXELS + (x + dx));
                    exp_data.push_back(col);
                end
    endfunction

    function automatic void model_clear();
        exp_addr.delete();
        exp_data.delete();
        for (int a = 0; a < H_PIXELS * V_PIXELS; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(int'(CLEAR_COLOR));
        end
    endfunction

    function automatic int first_bad();
        int n;
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++)
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) return i;
        if (got_addr.size() != exp_addr.size()) return n;
        return -1;
    endfunction

    task automatic start_paint(input int x, input int y, input int sw, input int col);
        cursor_loc_x = 10'(x);
        cursor_loc_y = 9'(y);
        stroke_width = 3'(sw);
        cursor_color = COLOR_W'(col);
        pen_down_in  = 1'b1;
        nf_in        = 1'b1;
        step();
        nf_in        = 1'b0;
        cursor_loc_x = 10'($urandom_range(0, 1023));
        cursor_loc_y = 9'($urandom_range(0, 511));
        stroke_width = 3'($urandom_range(0, 7));
        cursor_color = COLOR_W'($urandom_range(0, 15));
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL paint_start_busy: busy_out=%b, required 1", busy_out);
        end
    endtask

    // mode 0: ready always, 1: one on / two off, else random.
    task automatic run_job(input int mode, input int clr_at, input bit inject_nf,
                           input int stop_dones, input int budget,
                           output int busy_cycles, output int dones);
        bit held;
        bit nf_prev;
        int h_addr;
        int h_data;
        int n;
        got_addr.delete();
        got_data.delete();
        busy_cycles = 0;
        dones = 0;
        held = 1'b0;
        h_addr = 0;
        h_data = 0;
        n = 0;
        while (dones < stop_dones) begin
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL job_timeout: %0d done pulses after %0d cycles, required %0d", dones, n, stop_dones);
                break;
            end
            case (mode)
                0:       wr_ready_in = 1'b1;
                1:       wr_ready_in = (n % 3 == 0);
                default: wr_ready_in = 1'($urandom_range(0, 1));
            endcase
            if (held) begin
                checks++;
                if (wr_en_out !== 1'b1 || wr_addr_out !== ADDR_W'(h_addr) || wr_data_out !== COLOR_W'(h_data)) begin
                    errors++;
                    $display("FAIL hold_stable: en=%b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                             wr_en_out, wr_addr_out, wr_data_out, h_addr, h_data);
                end
            end
            clear_in = (clr_at > 0) && wr_en_out && wr_ready_in && (got_addr.size() == clr_at - 1);
            nf_in    = inject_nf && (n == 1);
            if (busy_out) busy_cycles++;
            if (wr_en_out && wr_ready_in) begin
                got_addr.push_back(int'(wr_addr_out));
                got_data.push_back(int'(wr_data_out));
            end
            held    = wr_en_out && !wr_ready_in;
            h_addr  = int'(wr_addr_out);
            h_data  = int'(wr_data_out);
            nf_prev = nf_in;
            step();
            clear_in = 1'b0;
            nf_in    = 1'b0;
            n++;
            checks++;
            if (frame_drop_out !== nf_prev) begin
                errors++;
                $display("FAIL frame_drop: frame_drop_out=%b, required %b", frame_drop_out, nf_prev);
            end
            if (done_out === 1'b1) dones++;
        end
        wr_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #2;
        checks++;
        if ({wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, frame_drop_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%h busy=%b done=%b drop=%b, required all 0",
                     wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, frame_drop_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step();
        step();
        checks++;
        if (busy_out !== 1'b0 || wr_en_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b en=%b, required 0 0", busy_out, wr_en_out);
        end
    endtask

    task automatic test_brush();
        int bc, d, fb;
        model_brush(10, 20, 2, 'hA);
        start_paint(10, 20, 2, 'hA);
        run_job(0, 0, 1'b0, 1, 200, bc, d);
        fb = first_bad();
        checks++;
        if (fb != -1) begin
            errors++;
            $display("FAIL brush_writes: first bad index %0d, got %0d writes, required %0d", fb, got_addr.size(), exp_addr.size());
        end
        checks++;
        if (bc != 9) begin
            errors++;
            $display("FAIL brush_cycles: %0d busy cycles, required 9", bc);
        end
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL brush_idle: busy_out=%b after done, required 0", busy_out);
        end
    endtask

    task automatic test_clip();
        int bc, d;
        int lit[4] = '{76478, 76479, 76798, 76799};
        start_paint(318, 238, 3, 'h5);
        run_job(0, 0, 1'b0, 1, 200, bc, d);
        checks++;
        if (got_addr.size() != 4) begin
            errors++;
            $display("FAIL clip_count: %0d writes, required 4", got_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_addr[i] != lit[i] || got_data[i] != 'h5) begin
                    errors++;
                    $display("FAIL clip_write: index %0d addr=%0d data=%h, required addr=%0d data=5", i, got_addr[i], got_data[i], lit[i]);
                end
            end
        end
        checks++;
        if (bc != 16) begin
            errors++;
            $display("FAIL clip_cycles: %0d PAINT cycles, required 16", bc);
        end
    endtask

    task automatic test_backpressure();
        int bc, d, fb;
        model_brush(10, 20, 2, 'hA);
        start_paint(10, 20, 2, 'hA);
        run_job(1, 0, 1'b0, 1, 400, bc, d);
        fb = first_bad();
        checks++;
        if (fb != -1) begin
            errors++;
            $display("FAIL backpressure_writes: first bad index %0d, got %0d writes, required %0d", fb, got_addr.size(), exp_addr.size());
        end
    endtask

    task automatic test_pen_up();
        pen_down_in = 1'b0;
        nf_in = 1'b1;
        step();
        nf_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || wr_en_out !== 1'b0 || frame_drop_out !== 1'b0) begin
            errors++;
            $display("FAIL pen_up: busy=%b en=%b drop=%b, required 0 0 0", busy_out, wr_en_out, frame_drop_out);
        end
    endtask

    task automatic test_random_brushes();
        int bc, d, fb, x, y, sw, col;
        for (int k = 0; k < 10; k++) begin
            x   = ($urandom_range(0, 1) == 1) ? $urandom_range(H_PIXELS - 8, H_PIXELS - 1) : $urandom_range(0, H_PIXELS - 1);
            y   = ($urandom_range(0, 1) == 1) ? $urandom_range(V_PIXELS - 8, V_PIXELS - 1) : $urandom_range(0, V_PIXELS - 1);
            sw  = $urandom_range(0, 7);
            col = $urandom_range(0, 15);
            model_brush(x, y, sw, col);
            start_paint(x, y, sw, col);
            run_job(2, 0, 1'($urandom_range(0, 1)), 1, 2000, bc, d);
            fb = first_bad();
            checks++;
            if (fb != -1) begin
                errors++;
                $display("FAIL random_brush: x=%0d y=%0d sw=%0d first bad index %0d, got %0d writes, required %0d",
                         x, y, sw, fb, got_addr.size(), exp_addr.size());
            end
        end
    endtask

    task automatic test_clear_vs_paint();
        int bc, d, fb;
        cursor_loc_x = 10'd5;
        cursor_loc_y = 9'd5;
        stroke_width = 3'd0;
        cursor_color = COLOR_W'(7);
        pen_down_in  = 1'b1;
        clear_in     = 1'b1;
        nf_in        = 1'b1;
        step();
        clear_in = 1'b0;
        nf_in    = 1'b0;
        checks++;
        if (busy_out !== 1'b1 || frame_drop_out !== 1'b1 || wr_en_out !== 1'b1 ||
            wr_addr_out !== '0 || wr_data_out !== CLEAR_COLOR) begin
            errors++;
            $display("FAIL clear_first: busy=%b drop=%b en=%b addr=%0d data=%h, required 1 1 1 0 %h",
                     busy_out, frame_drop_out, wr_en_out, wr_addr_out, wr_data_out, CLEAR_COLOR);
        end
        model_clear();
        run_job(0, 0, 1'b0, 1, 80000, bc, d);
        fb = first_bad();
        checks++;
        if (fb != -1) begin
            errors++;
            $display("FAIL clear_writes: first bad index %0d, got %0d writes, required %0d", fb, got_addr.size(), exp_addr.size());
        end
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: busy_out=%b after clear, required 0", busy_out);
        end
        model_brush(100, 50, 1, 'h3);
        start_paint(100, 50, 1, 'h3);
        run_job(0, 0, 1'b0, 1, 200, bc, d);
        fb = first_bad();
        checks++;
        if (fb != -1) begin
            errors++;
            $display("FAIL paint_after_clear: first bad index %0d, got %0d writes, required %0d", fb, got_addr.size(), exp_addr.size());
        end
    endtask

    task automatic test_clear_during_paint();
        int bc, d, fb;
        model_brush(10, 20, 2, 'hA);
        start_paint(10, 20, 2, 'hA);
        run_job(0, 3, 1'b0, 1, 200, bc, d);
        fb = first_bad();
        checks++;
        if (fb != -1) begin
            errors++;
            $display("FAIL clear_in_paint_writes: first bad index %0d, got %0d writes, required %0d", fb, got_addr.size(), exp_addr.size());
        end
        checks++;
        if (busy_out !== 1'b1 || wr_en_out !== 1'b1 || wr_addr_out !== '0 || wr_data_out !== CLEAR_COLOR) begin
            errors++;
            $display("FAIL clear_follows_paint: busy=%b en=%b addr=%0d data=%h, required 1 1 0 %h",
                     busy_out, wr_en_out, wr_addr_out, wr_data_out, CLEAR_COLOR);
        end
        wr_ready_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (wr_en_out !== 1'b1 || wr_addr_out !== ADDR_W'(k)) begin
                errors++;
                $display("FAIL clear_sweep: en=%b addr=%0d, required 1 %0d", wr_en_out, wr_addr_out, k);
            end
        end
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (wr_en_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL midjob_reset: en=%b busy=%b done=%b, required 0 0 0", wr_en_out, busy_out, done_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        wr_ready_in = 1'b0;
        step();
        step();
        checks++;
        if (busy_out !== 1'b0 || wr_en_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: busy=%b en=%b done=%b, required 0 0 0", busy_out, wr_en_out, done_out);
        end
    endtask

    initial begin
        test_reset();
        test_brush();
        test_clip();
        test_backpressure();
        test_pen_up();
        test_random_brushes();
        test_clear_vs_paint();
        test_clear_during_paint();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
